// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with a valid/ready handshake and a 2-entry
// skid buffer, so the stage runs at one entry per cycle even under
// back-pressure.
// Handshake: an entry moves on a clock edge where valid and ready are both high.
// push = in_valid & in_ready, pop = out_valid & out_ready. Valid never depends
// combinationally on ready, and in_ready depends only on registered state.
// A synchronous flush empties the stage and zeroes the control field, so the
// bubble it leaves carries no write enables.
// A saturating counter records the cycles in which the head was stalled.
module pipe_stage_buf #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // The state encoding equals the number of entries held, so occupancy
    // exposes the FSM state directly.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] head_data_next;
    logic [CTRL_W-1:0] head_ctrl;
    logic [CTRL_W-1:0] head_ctrl_next;
    logic [DATA_W-1:0] skid_data;
    logic [DATA_W-1:0] skid_data_next;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [CTRL_W-1:0] skid_ctrl_next;
    logic              push;
    logic              pop;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign out_data  = head_data;
    assign out_ctrl  = head_ctrl;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // State, head and skid registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            head_data <= '0;
            head_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state     <= state_next;
            head_data <= head_data_next;
            head_ctrl <= head_ctrl_next;
            skid_data <= skid_data_next;
            skid_ctrl <= skid_ctrl_next;
        end
    end

    // Next state and entry moves. Flush overrides everything else; a pop in
    // the flush cycle has still been taken by the downstream stage.
    always_comb begin
        state_next     = state;
        head_data_next = head_data;
        head_ctrl_next = head_ctrl;
        skid_data_next = skid_data;
        skid_ctrl_next = skid_ctrl;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next     = ONE;
                    head_data_next = in_data;
                    head_ctrl_next = in_ctrl;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_data_next = in_data;
                    head_ctrl_next = in_ctrl;
                end else if (push) begin
                    state_next     = FULL;
                    skid_data_next = in_data;
                    skid_ctrl_next = in_ctrl;
                end else if (pop) begin
                    state_next     = EMPTY;
                    head_ctrl_next = '0;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can move anything.
                if (pop) begin
                    state_next     = ONE;
                    head_data_next = skid_data;
                    head_ctrl_next = skid_ctrl;
                    skid_ctrl_next = '0;
                end
            end
            default: begin
                state_next     = EMPTY;
                head_ctrl_next = '0;
                skid_ctrl_next = '0;
            end
        endcase
        if (flush) begin
            // Payload may stay stale; only the control bits must read as zero.
            state_next     = EMPTY;
            head_ctrl_next = '0;
            skid_ctrl_next = '0;
        end
    end

    // Saturating count of cycles with the head presented but not accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: scenario tasks driving the stage, with a
// scoreboard queue of accepted entries compared against what the stage emits.
module tb_pipe_stage_buf;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;
  localparam int ENT_W  = DATA_W + CTRL_W;
  localparam int CNT_MAX = 15;

  logic              clock;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  logic [ENT_W-1:0] exp_q[$];
  int exp_stall;
  int n_tests;
  int n_fail;
  int n_pops;

  pipe_stage_buf #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  // One clock cycle: check outputs against the model at the negedge, update
  // the scoreboard with what the coming edge does, return at posedge + 1.
  task automatic cycle();
    logic [ENT_W-1:0] head;
    int occ;
    @(negedge clock);
    occ = exp_q.size();
    n_tests++;
    if (occupancy !== 2'(occ)) begin
      n_fail++;
      $display("FAIL occupancy: got %0d want %0d", occupancy, occ);
    end
    n_tests++;
    if (out_valid !== (occ != 0)) begin
      n_fail++;
      $display("FAIL out_valid: got %0b want %0b", out_valid, (occ != 0));
    end
    n_tests++;
    if (in_ready !== (occ != 2)) begin
      n_fail++;
      $display("FAIL in_ready: got %0b want %0b", in_ready, (occ != 2));
    end
    n_tests++;
    if (stall_cnt !== 4'(exp_stall)) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
    end
    if (occ == 0) begin
      n_tests++;
      if (out_ctrl !== '0) begin
        n_fail++;
        $display("FAIL bubble_ctrl: got %h want 0", out_ctrl);
      end
    end
    if (occ != 0 && out_ready) begin
      head = exp_q.pop_front();
      n_pops++;
      n_tests++;
      if (out_data !== head[DATA_W-1:0] || out_ctrl !== head[ENT_W-1:DATA_W]) begin
        n_fail++;
        $display("FAIL pop_entry: got data %h ctrl %h want data %h ctrl %h",
                 out_data, out_ctrl, head[DATA_W-1:0], head[ENT_W-1:DATA_W]);
      end
    end
    if (occ != 0 && !out_ready && exp_stall != CNT_MAX) exp_stall++;
    if (flush) exp_q.delete();
    else if (in_valid && occ != 2) exp_q.push_back({in_ctrl, in_data});
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0);
    for (int k = 0; k < 6; k++) cycle();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      flush = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), $urandom(), 16'($urandom()));
      @(negedge clock);
      n_tests++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 ||
          in_ready !== 1'b1 || stall_cnt !== '0 || out_data !== '0) begin
        n_fail++;
        $display("FAIL reset_state: got v%0b c%h o%0d r%0b s%0d d%h want v0 c0 o0 r1 s0 d0",
                 out_valid, out_ctrl, occupancy, in_ready, stall_cnt, out_data);
      end
    end
    @(posedge clock);
    #1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0);
    reset = 1'b1;
    exp_q.delete();
    exp_stall = 0;
    cycle();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, DATA_W'(i), 16'h01FF);
      cycle();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(i) || out_ctrl !== 16'h01FF || occupancy !== 2'd1) begin
        n_fail++;
        $display("FAIL stream_%0d: got v%0b d%0d c%h o%0d want v1 d%0d c01ff o1",
                 i, out_valid, out_data, out_ctrl, occupancy, i);
      end
    end
    drain();
  endtask

  task automatic test_back_pressure();
    int s0;
    int p0;
    s0 = exp_stall;
    p0 = n_pops;
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 16'h0A0A);
    cycle();
    drive(1'b1, 32'hB, 16'h0B0B);
    cycle();
    n_tests++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got o%0d r%0b want o2 r0", occupancy, in_ready);
    end
    drive(1'b1, 32'hC, 16'h0C0C);
    cycle();
    cycle();
    n_tests++;
    if (occupancy !== 2'd2 || out_data !== 32'hA) begin
      n_fail++;
      $display("FAIL bp_hold: got o%0d d%h want o2 d0000000a", occupancy, out_data);
    end
    n_tests++;
    if (stall_cnt !== 4'(s0 + 3)) begin
      n_fail++;
      $display("FAIL bp_stall_cnt: got %0d want %0d", stall_cnt, s0 + 3);
    end
    out_ready = 1'b1;
    cycle();
    cycle();
    drain();
    n_tests++;
    if (n_pops - p0 != 3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d pops want 3", n_pops - p0);
    end
  endtask

  task automatic test_flush();
    int p0;
    p0 = n_pops;
    out_ready = 1'b0;
    drive(1'b1, 32'h1A, 16'hFFFF);
    cycle();
    drive(1'b1, 32'h1B, 16'hFFFF);
    cycle();
    drive(1'b1, 32'h1C, 16'hFFFF);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    n_tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_bubble: got v%0b c%h o%0d want v0 c0 o0", out_valid, out_ctrl, occupancy);
    end
    drain();
    n_tests++;
    if (n_pops != p0) begin
      n_fail++;
      $display("FAIL flush_leak: got %0d pops want 0", n_pops - p0);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    drive(1'b1, 32'h55, 16'h0005);
    cycle();
    drive(1'b0, '0, '0);
    for (int k = 0; k < 20; k++) cycle();
    n_tests++;
    if (stall_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL stall_saturate: got %0d want 15", stall_cnt);
    end
    drain();
  endtask

  task automatic test_async_reset();
    int p0;
    out_ready = 1'b0;
    drive(1'b1, 32'h77, 16'h0707);
    cycle();
    drive(1'b1, 32'h88, 16'h0808);
    cycle();
    drive(1'b0, '0, '0);
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 ||
        in_ready !== 1'b1 || stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v%0b c%h o%0d r%0b s%0d want v0 c0 o0 r1 s0",
               out_valid, out_ctrl, occupancy, in_ready, stall_cnt);
    end
    exp_q.delete();
    exp_stall = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    p0 = n_pops;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, $urandom(), 16'($urandom()));
      cycle();
    end
    drain();
    n_tests++;
    if (n_pops - p0 != 5) begin
      n_fail++;
      $display("FAIL post_reset_stream: got %0d pops want 5", n_pops - p0);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 3) != 0), $urandom(), 16'($urandom()));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      cycle();
    end
    drain();
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    n_pops = 0;
    exp_stall = 0;
    reset = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_saturation();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
